// File: rtl/acionador_motor_pkg.sv
// Shared encodings and parameter defaults for the two-wheel motor driver.
package acionador_motor_pkg;

    typedef enum logic [1:0] {
        PARADO = 2'd0,
        FRENTE = 2'd1,
        GIRO   = 2'd2,
        PAUSA  = 2'd3
    } estado_t;

    typedef enum logic [1:0] {
        CMD_PARADO = 2'd0,
        CMD_FRENTE = 2'd1,
        CMD_GIRO   = 2'd2
    } cmd_t;

    localparam int PWM_PERIOD_DEF  = 100;
    localparam int RAMP_STEP_DEF   = 5;
    localparam int DUTY_MAX_DEF    = 80;
    localparam int DEAD_CYCLES_DEF = 50;

    // Conflicting or absent commands both mean stop.
    function automatic cmd_t decode_cmd(input logic avancar, input logic girar);
        if (avancar && !girar) return CMD_FRENTE;
        if (girar && !avancar) return CMD_GIRO;
        return CMD_PARADO;
    endfunction

    function automatic estado_t cmd_to_estado(input cmd_t cmd);
        case (cmd)
            CMD_FRENTE: return FRENTE;
            CMD_GIRO:   return GIRO;
            default:    return PARADO;
        endcase
    endfunction

endpackage

// File: rtl/acionador_motor_if.sv
// Command and wheel-drive signals between the navigation logic and the motor driver.
interface acionador_motor_if;
    // Level-sensitive commands, no valid/ready: the driver samples them every clock.
    logic       avancar;
    logic       girar;
    logic       pwm_esq;
    logic       pwm_dir;
    logic       dir_esq;
    logic       dir_dir;
    logic [1:0] estado;

    modport master (
        output avancar, girar,
        input  pwm_esq, pwm_dir, dir_esq, dir_dir, estado
    );

    modport slave (
        input  avancar, girar,
        output pwm_esq, pwm_dir, dir_esq, dir_dir, estado
    );
endinterface

// File: rtl/acionador_motor_gerador_pwm.sv
// Free-running PWM counter with a saturating per-period duty ramp and registered compare.
module gerador_pwm #(
    parameter int PWM_PERIOD = acionador_motor_pkg::PWM_PERIOD_DEF,
    parameter int RAMP_STEP  = acionador_motor_pkg::RAMP_STEP_DEF,
    parameter int DUTY_MAX   = acionador_motor_pkg::DUTY_MAX_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic ativo,
    output logic pwm
);
    localparam logic [7:0] ULTIMO = 8'(PWM_PERIOD - 1);
    localparam logic [7:0] DMAX   = 8'(DUTY_MAX);
    localparam logic [8:0] PASSO  = 9'(RAMP_STEP);

    logic [7:0] contador;
    logic [7:0] duty;
    logic [7:0] duty_prox;
    logic [8:0] soma;

    // Clamp on the 9-bit sum so a large step cannot wrap past DUTY_MAX.
    always_comb begin
        soma      = {1'b0, duty} + PASSO;
        duty_prox = (soma > {1'b0, DMAX}) ? DMAX : soma[7:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            contador <= 8'd0;
            duty     <= 8'd0;
            pwm      <= 1'b0;
        end else begin
            contador <= (contador == ULTIMO) ? 8'd0 : contador + 8'd1;
            if (!ativo)
                duty <= 8'd0;
            else if (contador == ULTIMO)
                duty <= duty_prox;
            pwm <= ativo && (contador < duty);
        end
    end
endmodule

// File: rtl/acionador_motor.sv
// Motor driver FSM: forward / in-place turn with dead time between direction reversals.
module acionador_motor
    import acionador_motor_pkg::*;
#(
    parameter int PWM_PERIOD  = PWM_PERIOD_DEF,
    parameter int RAMP_STEP   = RAMP_STEP_DEF,
    parameter int DUTY_MAX    = DUTY_MAX_DEF,
    parameter int DEAD_CYCLES = DEAD_CYCLES_DEF
) (
    input  logic            clock,
    input  logic            reset,
    acionador_motor_if.slave bus
);
    localparam logic [7:0] PAUSA_LEN = 8'(DEAD_CYCLES);

    estado_t    estado_q, estado_d;
    logic [7:0] pausa_q, pausa_d;
    cmd_t       cmd;
    logic       ativo;
    logic       pwm;
    logic       dir_esq_q, dir_dir_q;

    always_comb cmd = decode_cmd(bus.avancar, bus.girar);

    always_comb begin
        estado_d = estado_q;
        pausa_d  = pausa_q;
        case (estado_q)
            PARADO: estado_d = cmd_to_estado(cmd);
            FRENTE: begin
                if (cmd == CMD_PARADO) begin
                    estado_d = PARADO;
                end else if (cmd == CMD_GIRO) begin
                    estado_d = PAUSA;
                    pausa_d  = PAUSA_LEN;
                end
            end
            GIRO: begin
                if (cmd == CMD_PARADO) begin
                    estado_d = PARADO;
                end else if (cmd == CMD_FRENTE) begin
                    estado_d = PAUSA;
                    pausa_d  = PAUSA_LEN;
                end
            end
            PAUSA: begin
                // Leave on the last dead-time cycle using whatever is commanded then.
                if (pausa_q <= 8'd1) begin
                    estado_d = cmd_to_estado(cmd);
                    pausa_d  = 8'd0;
                end else begin
                    pausa_d = pausa_q - 8'd1;
                end
            end
            default: estado_d = PARADO;
        endcase
    end

    // Directions follow the registered state, so they lag estado by one clock.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= PARADO;
            pausa_q   <= 8'd0;
            dir_esq_q <= 1'b0;
            dir_dir_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            pausa_q  <= pausa_d;
            if (estado_q == FRENTE) begin
                dir_esq_q <= 1'b1;
                dir_dir_q <= 1'b1;
            end else if (estado_q == GIRO) begin
                dir_esq_q <= 1'b1;
                dir_dir_q <= 1'b0;
            end
        end
    end

    always_comb ativo = (estado_q == FRENTE) || (estado_q == GIRO);

    gerador_pwm #(
        .PWM_PERIOD (PWM_PERIOD),
        .RAMP_STEP  (RAMP_STEP),
        .DUTY_MAX   (DUTY_MAX)
    ) u_pwm (
        .clock (clock),
        .reset (reset),
        .ativo (ativo),
        .pwm   (pwm)
    );

    assign bus.pwm_esq = pwm;
    assign bus.pwm_dir = pwm;
    assign bus.dir_esq = dir_esq_q;
    assign bus.dir_dir = dir_dir_q;
    assign bus.estado  = estado_q;
endmodule
